// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: E-stage forwarding, load-use stall, branch flush,
// multi-cycle execute sequencing and a saturating stall-cycle counter.
module hazard_unit_mc #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              mc_start_e,
    input  logic              stat_clr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic          lwStall, mcStall, mcAccept;

    if (MC_LAT < 2) begin : gLatCheck
        $error("hazard_unit_mc: MC_LAT must be >= 2");
    end

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    assign lwStall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

    // Start cycle is qualified by ~rst so a held mc_start_e cannot keep stalls up during reset.
    assign mcAccept = (state == IDLE) && mc_start_e && !PCSrcE && !rst;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (mcAccept) begin
                    if (MC_LAT == 2) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = BUSY;
                        cntNext   = CW'(MC_LAT - 3);
                    end
                end
            end
            BUSY: begin
                if (cnt != '0)
                    cntNext = cnt - 1'b1;
                else
                    stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    assign mcStall = mcAccept || (state == BUSY);
    assign mc_busy = mcStall;
    assign mc_done = (state == DONE);

    assign StallF = lwStall || mcStall;
    assign StallD = lwStall || mcStall;
    assign StallE = mcStall;
    assign FlushD = PCSrcE;
    assign FlushE = PCSrcE || (lwStall && !mcStall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stat_clr)
            stall_cnt <= '0;
        else if (StallF && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    mcBranchExclusive: assert property (@(posedge clk) disable iff (rst) !(mc_start_e && PCSrcE))
        else $error("hazard_unit_mc: mc_start_e and PCSrcE asserted together");

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc; four instances share stimulus and cover
// MC_LAT=4/2/6 and a 3-bit stall counter.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, mc_start_e, stat_clr;

    logic [1:0]  fAE_a, fBE_a, fAE_b, fBE_b, fAE_c, fBE_c, fAE_d, fBE_d;
    logic        sF_a, sD_a, sE_a, fD_a, fE_a, busy_a, done_a;
    logic        sF_b, sD_b, sE_b, fD_b, fE_b, busy_b, done_b;
    logic        sF_c, sD_c, sE_c, fD_c, fE_c, busy_c, done_c;
    logic        sF_d, sD_d, sE_d, fD_d, fE_d, busy_d, done_d;
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic [2:0]  cnt_d;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .MC_LAT(4), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .mc_start_e(mc_start_e), .stat_clr(stat_clr),
        .ForwardAE(fAE_a), .ForwardBE(fBE_a), .StallF(sF_a), .StallD(sD_a), .StallE(sE_a),
        .FlushD(fD_a), .FlushE(fE_a), .mc_busy(busy_a), .mc_done(done_a), .stall_cnt(cnt_a));

    hazard_unit_mc #(.REG_AW(5), .MC_LAT(2), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .mc_start_e(mc_start_e), .stat_clr(stat_clr),
        .ForwardAE(fAE_b), .ForwardBE(fBE_b), .StallF(sF_b), .StallD(sD_b), .StallE(sE_b),
        .FlushD(fD_b), .FlushE(fE_b), .mc_busy(busy_b), .mc_done(done_b), .stall_cnt(cnt_b));

    hazard_unit_mc #(.REG_AW(5), .MC_LAT(6), .CNT_W(16)) dutC (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .mc_start_e(mc_start_e), .stat_clr(stat_clr),
        .ForwardAE(fAE_c), .ForwardBE(fBE_c), .StallF(sF_c), .StallD(sD_c), .StallE(sE_c),
        .FlushD(fD_c), .FlushE(fE_c), .mc_busy(busy_c), .mc_done(done_c), .stall_cnt(cnt_c));

    hazard_unit_mc #(.REG_AW(5), .MC_LAT(4), .CNT_W(3)) dutD (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .mc_start_e(mc_start_e), .stat_clr(stat_clr),
        .ForwardAE(fAE_d), .ForwardBE(fBE_d), .StallF(sF_d), .StallD(sD_d), .StallE(sE_d),
        .FlushD(fD_d), .FlushE(fE_d), .mc_busy(busy_d), .mc_done(done_d), .stall_cnt(cnt_d));

    task automatic clearInputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
        mc_start_e = 1'b0; stat_clr = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with reset released and inputs at 0.
    task automatic applyReset();
        clearInputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        #1;
        checks++;
        if ({fAE_a, fBE_a, sF_a, sD_a, sE_a, fD_a, fE_a, busy_a, done_a} !== 11'b0 || cnt_a !== 16'd0) begin
            failures++;
            $display("FAIL reset_during: outs=%b cnt=%0d required all 0", {fAE_a, fBE_a, sF_a, sD_a, sE_a, fD_a, fE_a, busy_a, done_a}, cnt_a);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({fAE_a, fBE_a, sF_a, sD_a, sE_a, fD_a, fE_a, busy_a, done_a} !== 11'b0 || cnt_a !== 16'd0) begin
            failures++;
            $display("FAIL reset_after: outs=%b cnt=%0d required all 0", {fAE_a, fBE_a, sF_a, sD_a, sE_a, fD_a, fE_a, busy_a, done_a}, cnt_a);
        end
    endtask

    task automatic test_forward();
        applyReset();
        RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
        checks++;
        if (fAE_a !== 2'b10) begin failures++; $display("FAIL fwd_m_priority: got %b want 10", fAE_a); end
        RegWriteM = 1'b0; #1;
        checks++;
        if (fAE_a !== 2'b01) begin failures++; $display("FAIL fwd_w: got %b want 01", fAE_a); end
        Rs2E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd0; #1;
        checks++;
        if (fBE_a !== 2'b00) begin failures++; $display("FAIL fwd_x0: got %b want 00", fBE_a); end
        Rs2E = 5'd9; RdW = 5'd9; RdM = 5'd3; Rs1E = 5'd3; #1;
        checks++;
        if (fBE_a !== 2'b01 || fAE_a !== 2'b10) begin
            failures++; $display("FAIL fwd_split: A=%b B=%b want A=10 B=01", fAE_a, fBE_a);
        end
        RegWriteW = 1'b0; #1;
        checks++;
        if (fBE_a !== 2'b00) begin failures++; $display("FAIL fwd_nowrite: got %b want 00", fBE_a); end
    endtask

    task automatic test_load_use();
        applyReset();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd2; #1;
        checks++;
        if ({sF_a, sD_a, fE_a, sE_a} !== 4'b1110) begin
            failures++; $display("FAIL lw_stall: F,D,FlushE,E=%b want 1110", {sF_a, sD_a, fE_a, sE_a});
        end
        RdE = 5'd0; Rs2D = 5'd0; #1;
        checks++;
        if ({sF_a, sD_a, fE_a, sE_a} !== 4'b0000) begin
            failures++; $display("FAIL lw_x0: F,D,FlushE,E=%b want 0000", {sF_a, sD_a, fE_a, sE_a});
        end
        RdE = 5'd7; Rs1D = 5'd7; ResultSrcE0 = 1'b0; #1;
        checks++;
        if ({sF_a, fE_a} !== 2'b00) begin
            failures++; $display("FAIL lw_notload: F,FlushE=%b want 00", {sF_a, fE_a});
        end
    endtask

    task automatic test_branch_flush();
        applyReset();
        PCSrcE = 1'b1; #1;
        checks++;
        if ({fD_a, fE_a, sF_a, sE_a} !== 4'b1100) begin
            failures++; $display("FAIL branch_flush: FD,FE,SF,SE=%b want 1100", {fD_a, fE_a, sF_a, sE_a});
        end
        ResultSrcE0 = 1'b1; RdE = 5'd4; Rs1D = 5'd4; #1;
        checks++;
        if ({fD_a, fE_a, sF_a} !== 3'b111) begin
            failures++; $display("FAIL branch_lw: FD,FE,SF=%b want 111", {fD_a, fE_a, sF_a});
        end
    endtask

    task automatic test_mc_lat4();
        logic expStall;
        applyReset();
        mc_start_e = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) mc_start_e = 1'b0;
            #1;
            expStall = (k < 3);
            checks++;
            if ({sF_a, sD_a, sE_a, busy_a} !== {4{expStall}} || done_a !== (k == 3) || fE_a !== 1'b0
                || cnt_a !== 16'((k < 3) ? k : 3)) begin
                failures++;
                $display("FAIL mc4_cycle%0d: FDE busy=%b done=%b FlushE=%b cnt=%0d want stall=%b done=%b FlushE=0 cnt=%0d",
                         k, {sF_a, sD_a, sE_a, busy_a}, done_a, fE_a, cnt_a, expStall, (k == 3), (k < 3) ? k : 3);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mc_lat2();
        applyReset();
        mc_start_e = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mc_start_e = 1'b0;
            #1;
            checks++;
            if ({sF_b, sE_b} !== {2{k == 0}} || done_b !== (k == 1) || cnt_b !== 16'((k == 0) ? 0 : 1)) begin
                failures++;
                $display("FAIL mc2_cycle%0d: SF,SE=%b done=%b cnt=%0d want stall=%b done=%b",
                         k, {sF_b, sE_b}, done_b, cnt_b, (k == 0), (k == 1));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_during_busy();
        applyReset();
        mc_start_e = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7; #1;
        checks++;
        if ({fE_a, sE_a, sF_a} !== 3'b011) begin
            failures++; $display("FAIL lw_mc_start: FE,SE,SF=%b want 011", {fE_a, sE_a, sF_a});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy_a, fE_a, sE_a} !== 3'b101) begin
            failures++; $display("FAIL lw_mc_busy: busy,FE,SE=%b want 101", {busy_a, fE_a, sE_a});
        end
        @(posedge clk); @(posedge clk); #1;
        mc_start_e = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy_a, fE_a, sE_a, sF_a} !== 4'b0101) begin
            failures++; $display("FAIL lw_after_mc: busy,FE,SE,SF=%b want 0101", {busy_a, fE_a, sE_a, sF_a});
        end
    endtask

    task automatic test_reset_midop();
        applyReset();
        mc_start_e = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({sF_c, sE_c, busy_c} !== 3'b111) begin
            failures++; $display("FAIL mid_pre: SF,SE,busy=%b want 111", {sF_c, sE_c, busy_c});
        end
        rst = 1'b1; #1;
        checks++;
        if ({sF_c, sD_c, sE_c, busy_c, done_c} !== 5'b0) begin
            failures++; $display("FAIL mid_reset: SF,SD,SE,busy,done=%b want 00000", {sF_c, sD_c, sE_c, busy_c, done_c});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) mc_start_e = 1'b0;
            #1;
            checks++;
            if ({sF_c, sE_c} !== {2{k < 5}} || done_c !== (k == 5)) begin
                failures++;
                $display("FAIL mid_fresh%0d: SF,SE=%b done=%b want stall=%b done=%b", k, {sF_c, sE_c}, done_c, (k < 5), (k == 5));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        applyReset();
        ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin
                checks++;
                if (cnt_d !== 3'd5) begin failures++; $display("FAIL sat_mid: cnt=%0d want 5", cnt_d); end
            end
        end
        checks++;
        if (cnt_d !== 3'd7 || cnt_a !== 16'd10) begin
            failures++; $display("FAIL sat_hold: cnt3=%0d cnt16=%0d want 7 and 10", cnt_d, cnt_a);
        end
        stat_clr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cnt_d !== 3'd0 || sF_d !== 1'b1) begin
            failures++; $display("FAIL sat_clr: cnt=%0d StallF=%b want 0 and 1", cnt_d, sF_d);
        end
        stat_clr = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cnt_d !== 3'd1) begin failures++; $display("FAIL sat_resume: cnt=%0d want 1", cnt_d); end
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        #2;
        test_reset();
        test_forward();
        test_load_use();
        test_branch_flush();
        test_mc_lat4();
        test_mc_lat2();
        test_lw_during_busy();
        test_reset_midop();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised pipeline hazard unit for the 5-stage RISC-V core. It generates E-stage forwarding selects, load-use stalls and branch flushes. It also owns a sequencing FSM that holds the pipeline for a fixed-latency multi-cycle execute op (mul/div), so the datapath no longer drives an external stall. A saturating stall-cycle counter is provided for performance visibility.

Parameters:
REG_AW, 5, register address width
MC_LAT, 4, total cycles a multi-cycle op occupies E; legal range >= 2
CNT_W, 16, width of stall-cycle counter

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
Rs1D  input  REG_AW  rs1 of instruction in D
Rs2D  input  REG_AW  rs2 of instruction in D
Rs1E  input  REG_AW  rs1 of instruction in E
Rs2E  input  REG_AW  rs2 of instruction in E
RdE  input  REG_AW  destination register in E
RdM  input  REG_AW  destination register in M
RdW  input  REG_AW  destination register in W
RegWriteM  input  1  M-stage instruction writes Rd
RegWriteW  input  1  W-stage instruction writes Rd
ResultSrcE0  input  1  E-stage instruction is a load
PCSrcE  input  1  taken branch/jump resolved in E
mc_start_e  input  1  E-stage instruction is a multi-cycle op; held high while it sits in E
stat_clr  input  1  synchronous clear of stall_cnt
ForwardAE  output  2  operand A select: 00 regfile, 01 W result, 10 M ALU result
ForwardBE  output  2  operand B select, same encoding
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register (bubble)
mc_busy  output  1  FSM in BUSY or start cycle
mc_done  output  1  multi-cycle result valid this cycle; op leaves E at next edge
stall_cnt  output  CNT_W  cycles with StallF=1 since reset/clear

Behaviour:
- Forwarding, combinational, per operand (RsE = Rs1E or Rs2E):
  - 10 if RegWriteM & RdM!=0 & RdM==RsE.
  - else 01 if RegWriteW & RdW!=0 & RdW==RsE.
  - else 00.
  - M has priority over W. x0 is never forwarded.
- lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- FSM states: IDLE, BUSY, DONE. Reset to IDLE. Internal counter cnt is $clog2(MC_LAT) bits, minimum 1 bit, and resets to 0.
  - IDLE & mc_start_e & ~PCSrcE:
    - MC_LAT==2: go to DONE.
    - MC_LAT>=3: go to BUSY and load cnt=MC_LAT-3.
  - BUSY: if cnt!=0, decrement. If cnt==0, go to DONE.
  - DONE: go to IDLE unconditionally. mc_start_e is ignored in DONE because it is the same op.
- mcStall = (IDLE & mc_start_e & ~PCSrcE) | BUSY. It is asserted for exactly MC_LAT-1 consecutive cycles per op.
- mc_busy = mcStall. mc_done = (state==DONE).
- Stall and flush outputs:
  - StallF = StallD = lwStall | mcStall.
  - StallE = mcStall.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | (lwStall & ~mcStall). A held E op must not be bubbled.
- mc_start_e with PCSrcE in the same cycle is illegal. PCSrcE wins, the FSM stays IDLE, and a simulation assertion fires.
- stall_cnt:
  - At rising edge: stat_clr → 0; else if StallF & stall_cnt != all-ones → +1.
  - Saturates at 2^CNT_W-1.
  - stat_clr has priority over increment.
- Reset values: state IDLE, cnt 0, stall_cnt 0. With inputs at 0, all outputs are 0 during and after reset.
- Reset mid-op: the FSM returns to IDLE immediately and stalls drop asynchronously.
- Forwarding outputs are unaffected by stalls.
- Elaboration error if MC_LAT<2.

Test Plan:
1. Forward priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. Then RegWriteM=0 → 01. Rs2E=0, RdM=0, RegWriteM=1 → ForwardBE=00.
2. Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, StallE=0. Same with RdE=0 → all 0.
3. Multi-cycle, MC_LAT=4: mc_start_e high from cycle t → StallF/D/E=1 on t..t+2, mc_done=1 only at t+3, stall_cnt increases by 3. Also run MC_LAT=2: stall at t only, mc_done at t+1.
4. lwStall during BUSY: ResultSrcE0=1 with a matching Rs1D while mc_busy → FlushE=0, StallE=1.
5. Reset mid-op: rst pulsed at cycle t+1 of an MC_LAT=6 op → stalls 0 within the reset cycle. After release with mc_start_e=1, a fresh 5-cycle stall occurs.
6. Counter saturation and clear: CNT_W=3, hold stall 10 cycles → stall_cnt=7. stat_clr together with StallF → 0 next cycle.
